// File: rtl/serial_add_driver_pkg.sv
// Shared types and defaults for the bit-serial adder link driver.
// Imported by the interface, the sck generator and the top.
package serial_add_pkg;
  localparam int DEFAULT_WIDTH    = 24;
  localparam int DEFAULT_HALF_DIV = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SHIFT,
    FLUSH
  } state_t;
endpackage

// File: rtl/serial_add_driver_if.sv
// Host-side operand/result handshake bundle for serial_add_driver.
// The master drives operands; the slave (the driver) returns the captured sum.
interface serial_add_driver_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_valid;
  logic             busy;

  modport master (
    output a_data, b_data, in_valid,
    input  in_ready, res_data, res_valid, busy
  );

  modport slave (
    input  a_data, b_data, in_valid,
    output in_ready, res_data, res_valid, busy
  );
endinterface

// File: rtl/serial_add_driver_sck_gen.sv
// Free-running serial clock divider: sck toggles every HALF_DIV clk cycles.
// rise/fall are single-clk strobes coinciding with the clk edge that toggles sck.
module serial_add_driver_sck_gen
  import serial_add_pkg::*;
#(
  parameter int HALF_DIV = DEFAULT_HALF_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic sck,
  output logic rise,
  output logic fall
);
  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [CW-1:0] div_cnt_reg;
  logic          sck_reg;
  logic          wrap;

  assign wrap = (div_cnt_reg == CW'(HALF_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg <= '0;
      sck_reg     <= 1'b0;
    end else if (wrap) begin
      div_cnt_reg <= '0;
      sck_reg     <= ~sck_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + CW'(1);
    end
  end

  assign sck  = sck_reg;
  assign rise = wrap & ~sck_reg;
  assign fall = wrap & sck_reg;
endmodule

// File: rtl/serial_add_driver.sv
// Transmit side of the two-stream bit-serial adder link: serialises A/B LSB-first
// behind a ws edge and reassembles the returned serial sum into res_data.
module serial_add_driver
  import serial_add_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int HALF_DIV = DEFAULT_HALF_DIV
) (
  input  logic                clk,
  input  logic                reset,
  serial_add_driver_if.slave  bus,
  output logic                sck,
  output logic                ws,
  output logic                sd1,
  output logic                sd2,
  input  logic                sd_ret
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-2:0] res_sh_reg;
  logic [WIDTH-1:0] res_data_reg;
  logic             ws_reg;
  logic             sd1_reg;
  logic             sd2_reg;
  logic             in_ready_reg;
  logic             res_valid_reg;
  logic             busy_reg;

  logic             rise;
  logic             handshake;
  logic [WIDTH-1:0] res_cat;

  serial_add_driver_sck_gen #(.HALF_DIV(HALF_DIV)) u_sck_gen (
    .clk   (clk),
    .reset (reset),
    .sck   (sck),
    .rise  (rise),
    .fall  ()
  );

  assign handshake = bus.in_valid & in_ready_reg;
  // Incoming sum bit on top; bit 0 of res_cat is the oldest captured sum bit.
  assign res_cat   = {sd_ret, res_sh_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      res_sh_reg    <= '0;
      res_data_reg  <= '0;
      ws_reg        <= 1'b0;
      sd1_reg       <= 1'b0;
      sd2_reg       <= 1'b0;
      in_ready_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      res_valid_reg <= 1'b0;
      if (res_valid_reg) busy_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          // in_ready stays low through the res_valid clk, so a new frame
          // starts at the earliest in the clk after it.
          if (handshake) begin
            a_sh_reg     <= bus.a_data;
            b_sh_reg     <= bus.b_data;
            bit_cnt_reg  <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= ARM;
          end else begin
            in_ready_reg <= 1'b1;
          end
        end

        ARM: begin
          if (rise) begin
            ws_reg    <= ~ws_reg;
            state_reg <= SHIFT;
          end
        end

        SHIFT: begin
          if (rise) begin
            sd1_reg     <= a_sh_reg[0];
            sd2_reg     <= b_sh_reg[0];
            a_sh_reg    <= a_sh_reg >> 1;
            b_sh_reg    <= b_sh_reg >> 1;
            // Sum bit i arrives one RISE after operand bit i was driven.
            if (bit_cnt_reg != '0) res_sh_reg <= res_cat[WIDTH-1:1];
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
            if (bit_cnt_reg == CNT_W'(WIDTH - 1)) state_reg <= FLUSH;
          end
        end

        FLUSH: begin
          if (rise) begin
            res_data_reg  <= res_cat;
            sd1_reg       <= 1'b0;
            sd2_reg       <= 1'b0;
            res_valid_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ws            = ws_reg;
  assign sd1           = sd1_reg;
  assign sd2           = sd2_reg;
  assign bus.in_ready  = in_ready_reg;
  assign bus.res_data  = res_data_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_serial_add_driver.sv
// Directed bench for serial_add_driver with a behavioural serial adder on the link.
// Two instances: default 24-bit/HALF_DIV=2 and an 8-bit/HALF_DIV=1 variant.
module tb_serial_add_driver;
  import serial_add_pkg::*;

  localparam int W  = 24;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  serial_add_driver_if #(.WIDTH(W))  bus ();
  serial_add_driver_if #(.WIDTH(W8)) bus8 ();

  logic sck, ws, sd1, sd2;
  logic sd_ret = 1'b0;
  logic sck8, ws8, sd1_8, sd2_8;
  logic sd_ret8 = 1'b0;

  serial_add_driver #(.WIDTH(W), .HALF_DIV(2)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave),
    .sck(sck), .ws(ws), .sd1(sd1), .sd2(sd2), .sd_ret(sd_ret)
  );

  serial_add_driver #(.WIDTH(W8), .HALF_DIV(1)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8.slave),
    .sck(sck8), .ws(ws8), .sd1(sd1_8), .sd2(sd2_8), .sd_ret(sd_ret8)
  );

  int errors = 0;
  int checks = 0;

  // Reference serial adder: a ws edge seen on sck fall starts a frame,
  // each later fall samples one operand bit pair and returns the sum bit.
  logic       m_last_ws = 1'b0, m_active = 1'b0, m_carry = 1'b0;
  int         m_cnt = 0;
  logic [1:0] m_sum;
  always @(negedge sck or posedge reset) begin
    if (reset) begin
      m_last_ws = 1'b0; m_active = 1'b0; m_carry = 1'b0; m_cnt = 0;
      sd_ret <= 1'b0;
    end else if (ws !== m_last_ws) begin
      m_last_ws = ws; m_active = 1'b1; m_carry = 1'b0; m_cnt = 0;
    end else if (m_active) begin
      m_sum = 2'(sd1) + 2'(sd2) + 2'(m_carry);
      sd_ret <= m_sum[0];
      m_carry = m_sum[1];
      m_cnt++;
      if (m_cnt == W) m_active = 1'b0;
    end
  end

  logic       n_last_ws = 1'b0, n_active = 1'b0, n_carry = 1'b0;
  int         n_cnt = 0;
  logic [1:0] n_sum;
  always @(negedge sck8 or posedge reset) begin
    if (reset) begin
      n_last_ws = 1'b0; n_active = 1'b0; n_carry = 1'b0; n_cnt = 0;
      sd_ret8 <= 1'b0;
    end else if (ws8 !== n_last_ws) begin
      n_last_ws = ws8; n_active = 1'b1; n_carry = 1'b0; n_cnt = 0;
    end else if (n_active) begin
      n_sum = 2'(sd1_8) + 2'(sd2_8) + 2'(n_carry);
      sd_ret8 <= n_sum[0];
      n_carry = n_sum[1];
      n_cnt++;
      if (n_cnt == W8) n_active = 1'b0;
    end
  end

  // Offers operands from a negedge; returns at the negedge after the accepting posedge.
  task automatic hs24(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold, output bit ok);
    bus.a_data = a;
    bus.b_data = b;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  // Watches one frame until res_valid, then one extra clk for a repeated pulse.
  task automatic collect24(output logic [W-1:0] res, output int rises, output int pulses,
                           output logic [W-1:0] s1, output logic [W-1:0] s2,
                           output int ready_hi, output int busy_lo, output bit done);
    logic prev;
    prev = sck;
    res = '0; rises = 0; pulses = 0; s1 = '0; s2 = '0;
    ready_hi = 0; busy_lo = 0; done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (sck && !prev) begin
        rises++;
        if (rises >= 2 && rises <= W + 1) begin
          s1[rises-2] = sd1;
          s2[rises-2] = sd2;
        end
      end
      prev = sck;
      if (bus.in_ready) ready_hi++;
      if (!bus.busy) busy_lo++;
      if (bus.res_valid) begin
        pulses++;
        res = bus.res_data;
        done = 1'b1;
        break;
      end
    end
    @(negedge clk);
    if (bus.res_valid) pulses++;
    $display("frame a=%h b=%h res=%h rises=%0d pulses=%0d", bus.a_data, bus.b_data, res, rises, pulses);
  endtask

  task automatic test_reset;
    logic [5:0] exp_sck;
    logic [5:0] exp_sck8;
    exp_sck  = 6'b100110;
    exp_sck8 = 6'b010101;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sck, ws, sd1, sd2} !== 4'b0000) begin
      errors++; $display("FAIL reset_lines: got %b required 0000", {sck, ws, sd1, sd2});
    end
    checks++;
    if ({bus.in_ready, bus.res_valid, bus.busy} !== 3'b000 || bus.res_data !== '0) begin
      errors++;
      $display("FAIL reset_bus: rdy/vld/busy=%b res=%h required 000/0", {bus.in_ready, bus.res_valid, bus.busy}, bus.res_data);
    end
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++;
      if (sck !== exp_sck[n] || sck8 !== exp_sck8[n]) begin
        errors++;
        $display("FAIL sck_div clk%0d: got %b/%b required %b/%b", n + 1, sck, sck8, exp_sck[n], exp_sck8[n]);
      end
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b required 1", bus.in_ready);
    end
    $display("reset released, sck phase checked");
  endtask

  task automatic test_basic;
    logic [W-1:0] res, s1, s2;
    int rises, pulses, rh, bl;
    bit ok, done;
    hs24(24'h000003, 24'h000005, 1'b0, ok);
    collect24(res, rises, pulses, s1, s2, rh, bl, done);
    checks++;
    if (!ok || !done) begin errors++; $display("FAIL basic_timeout: hs=%0d done=%0d required 1/1", ok, done); end
    checks++;
    if (res !== 24'h000008) begin errors++; $display("FAIL basic_res: got %h required 000008", res); end
    checks++;
    if (rises !== 26) begin errors++; $display("FAIL basic_rises: got %0d required 26", rises); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL basic_pulses: got %0d required 1", pulses); end
    checks++;
    if (s1 !== 24'h000003 || s2 !== 24'h000005) begin
      errors++; $display("FAIL basic_serial: sd1=%h sd2=%h required 000003/000005", s1, s2);
    end
    checks++;
    if ({sd1, sd2, bus.busy, bus.in_ready} !== 4'b0001) begin
      errors++; $display("FAIL basic_idle: sd1/sd2/busy/rdy=%b required 0001", {sd1, sd2, bus.busy, bus.in_ready});
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] res, s1, s2;
    int rises, pulses, rh, bl;
    bit ok, done;
    logic ws_a;
    hs24(24'hFFFFFF, 24'h000001, 1'b0, ok);
    collect24(res, rises, pulses, s1, s2, rh, bl, done);
    ws_a = ws;
    checks++;
    if (!ok || !done || res !== 24'h000000) begin
      errors++; $display("FAIL wrap_res: got %h (hs=%0d done=%0d) required 000000", res, ok, done);
    end
    hs24(24'h123456, 24'h111111, 1'b0, ok);
    collect24(res, rises, pulses, s1, s2, rh, bl, done);
    checks++;
    if (!ok || !done || res !== 24'h234567) begin
      errors++; $display("FAIL b2b_res: got %h (hs=%0d done=%0d) required 234567", res, ok, done);
    end
    checks++;
    if (ws !== ~ws_a) begin errors++; $display("FAIL b2b_ws: got %b required %b", ws, ~ws_a); end
  endtask

  task automatic test_busy_ignore;
    logic [W-1:0] res, s1, s2;
    int rises, pulses, rh, bl;
    bit ok, done;
    hs24(24'h00ABCD, 24'h001111, 1'b1, ok);
    bus.a_data = 24'hFFFFFF;
    bus.b_data = 24'hFFFFFF;
    collect24(res, rises, pulses, s1, s2, rh, bl, done);
    checks++;
    if (!ok || !done || res !== 24'h00BCDE) begin
      errors++; $display("FAIL busy_res: got %h required 00BCDE", res);
    end
    checks++;
    if (rh !== 0 || bl !== 0) begin
      errors++; $display("FAIL busy_flags: ready_hi=%0d busy_lo=%0d required 0/0", rh, bl);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL busy_rearm: got %b required 1", bus.in_ready); end
    hs24(24'h0F0F0F, 24'h010101, 1'b0, ok);
    collect24(res, rises, pulses, s1, s2, rh, bl, done);
    checks++;
    if (!ok || !done || res !== 24'h101010) begin
      errors++; $display("FAIL busy_next: got %h required 101010", res);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [W-1:0] res, s1, s2;
    int rises, pulses, rh, bl, r, stray;
    bit ok, done;
    logic prev;
    hs24(24'h0000FF, 24'h000F00, 1'b0, ok);
    prev = sck; r = 0; stray = 0;
    for (int c = 0; c < 200 && r < 10; c++) begin
      @(negedge clk);
      if (sck && !prev) r++;
      prev = sck;
      if (bus.res_valid) stray++;
    end
    checks++;
    if (r !== 10) begin errors++; $display("FAIL mid_rises: got %0d required 10", r); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({sck, ws, sd1, sd2, bus.in_ready, bus.busy, bus.res_valid} !== 7'b0 || bus.res_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: lines=%b res=%h required 0000000/0",
               {sck, ws, sd1, sd2, bus.in_ready, bus.busy, bus.res_valid}, bus.res_data);
    end
    reset = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (bus.res_valid) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL mid_no_valid: got %0d pulses required 0", stray); end
    hs24(24'h000001, 24'h000002, 1'b0, ok);
    collect24(res, rises, pulses, s1, s2, rh, bl, done);
    checks++;
    if (!ok || !done || res !== 24'h000003 || pulses !== 1) begin
      errors++; $display("FAIL mid_fresh: got %h pulses=%0d required 000003/1", res, pulses);
    end
  endtask

  task automatic test_fast_div;
    logic [W8-1:0] res, s1;
    int rises, viol;
    bit ok, done;
    logic prev, p1, p2;
    @(negedge clk);
    bus8.a_data = 8'hAA;
    bus8.b_data = 8'h55;
    bus8.in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus8.in_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;
    prev = sck8; p1 = sd1_8; p2 = sd2_8;
    rises = 0; viol = 0; done = 1'b0; res = '0; s1 = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if ((sd1_8 !== p1 || sd2_8 !== p2) && !(sck8 && !prev)) viol++;
      if (sck8 && !prev) begin
        rises++;
        if (rises >= 2 && rises <= W8 + 1) s1[rises-2] = sd1_8;
      end
      prev = sck8; p1 = sd1_8; p2 = sd2_8;
      if (bus8.res_valid) begin res = bus8.res_data; done = 1'b1; break; end
    end
    $display("frame8 a=%h b=%h res=%h rises=%0d", bus8.a_data, bus8.b_data, res, rises);
    checks++;
    if (!ok || !done || res !== 8'hFF) begin
      errors++; $display("FAIL fast_res: got %h (hs=%0d done=%0d) required FF", res, ok, done);
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL fast_edges: got %0d off-rise changes required 0", viol); end
    checks++;
    if (rises !== W8 + 2 || s1 !== 8'hAA) begin
      errors++; $display("FAIL fast_serial: rises=%0d sd1=%h required 10/AA", rises, s1);
    end
  endtask

  initial begin
    bus.a_data = '0; bus.b_data = '0; bus.in_valid = 1'b0;
    bus8.a_data = '0; bus8.b_data = '0; bus8.in_valid = 1'b0;
    test_reset();
    @(negedge clk);
    test_basic();
    test_back_to_back();
    @(negedge clk);
    test_busy_ignore();
    @(negedge clk);
    test_reset_mid_frame();
    test_fast_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
